booth_divider: RTL and testbench

- Sequential signed divider, the inverse operation of the team's sequential Booth multiplier.
- Divides a 2*DATAWIDTH-bit signed dividend by a DATAWIDTH-bit signed divisor, one radix-2 restoring step per clock.
- Produces a DATAWIDTH-bit quotient and remainder, with truncating (round-toward-zero) semantics.
- Uses the same start/done handshake as the multiplier, so a datapath can pair the two (e.g. divide back a product).

---
 rtl/booth_divider.sv | 123 ++++++++++++
 tb/tb_booth_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, one restoring step
// per clock, truncating quotient and dividend-signed remainder, start/done handshake.
module booth_divider #(
  parameter int DATAWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2*DATAWIDTH-1:0]   dividend,
  input  logic [DATAWIDTH-1:0]     divisor,
  output logic [DATAWIDTH-1:0]     quotient,
  output logic [DATAWIDTH-1:0]     remainder,
  output logic                     div_by_zero,
  output logic                     overflow,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  // Handshake: start is sampled only in IDLE; done is high for the whole FINISH
  // state and the result is held until start is seen low, then the FSM idles.
  localparam int W  = DATAWIDTH;
  localparam int DW = 2 * DATAWIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           sign_q, sign_r;
  logic [DW-1:0]  dvd_sr;
  logic [W:0]     prem;
  logic [W-1:0]   dvs;
  logic [CW-1:0]  count;

  logic [W+1:0]   shifted;
  logic           fits;
  logic [W:0]     prem_nxt;
  logic [DW-1:0]  q_nxt;
  logic [DW-1:0]  dvd_abs;
  logic [W-1:0]   dvs_abs;
  logic           q_ovf;
  logic [W-1:0]   q_fin, r_fin;
  logic           last_iter;

  always_comb begin
    shifted  = {prem, dvd_sr[DW-1]};
    fits     = (shifted >= {2'b00, dvs});
    prem_nxt = fits ? (W+1)'(shifted - {2'b00, dvs}) : shifted[W:0];
    q_nxt    = {dvd_sr[DW-2:0], fits};
    dvd_abs  = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
    dvs_abs  = divisor[W-1] ? (~divisor + W'(1)) : divisor;
    // A negative quotient may reach one further in magnitude than a positive one.
    q_ovf    = sign_q ? (q_nxt > DW'(2 ** (W - 1))) : (q_nxt > DW'(2 ** (W - 1) - 1));
    q_fin    = sign_q ? (~q_nxt[W-1:0] + W'(1)) : q_nxt[W-1:0];
    r_fin    = sign_r ? (~prem_nxt[W-1:0] + W'(1)) : prem_nxt[W-1:0];
    last_iter = (count == CW'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? FINISH : RUN;
      RUN:     if (last_iter) state_nxt = FINISH;
      FINISH:  if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign done      = (state == FINISH);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dvd_sr      <= '0;
      prem        <= '0;
      dvs         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q      <= dividend[DW-1] ^ divisor[W-1];
            sign_r      <= dividend[DW-1];
            dvd_sr      <= dvd_abs;
            dvs         <= dvs_abs;
            prem        <= '0;
            count       <= CW'(DW);
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= (divisor == '0);
          end
        end
        RUN: begin
          prem   <= prem_nxt;
          dvd_sr <= q_nxt;
          count  <= count - CW'(1);
          if (last_iter) begin
            overflow  <= q_ovf;
            quotient  <= q_ovf ? '0 : q_fin;
            remainder <= q_ovf ? '0 : r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Randomized and directed bench for booth_divider: integer reference model,
// expected-result queue, and a monitor that checks every rising done.
module tb_booth_divider;

  localparam int W  = 8;
  localparam int EW = 2 * W + 2;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [2*W-1:0]       dividend;
  logic [W-1:0]         divisor;
  logic [W-1:0]         quotient;
  logic [W-1:0]         remainder;
  logic                 div_by_zero;
  logic                 overflow;
  logic                 done;
  logic [1:0]           state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic          done_d;

  booth_divider #(.DATAWIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer division truncates toward zero and % follows the dividend.
  // Packed as {div_by_zero, overflow, quotient, remainder}.
  function automatic logic [EW-1:0] model(input int a, input int b);
    int q, r;
    if (b == 0) return {1'b1, 1'b0, {(2*W){1'b0}}};
    q = a / b;
    r = a % b;
    if (q > 127 || q < -128) return {1'b0, 1'b1, {(2*W){1'b0}}};
    return {1'b0, 1'b0, W'(q), W'(r)};
  endfunction

  // monitor: one result per rising done
  always @(negedge clk) begin
    if (rst_n && done && !done_d) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got result %0h with no expected entry",
                 {div_by_zero, overflow, quotient, remainder});
      end else begin
        mon_e = exp_q.pop_front();
        check("result{dz,ov,q,r}", 64'({div_by_zero, overflow, quotient, remainder}), 64'(mon_e));
      end
    end
    done_d <= rst_n ? done : 1'b0;
  end

  task automatic drive_start(input int lat, input bit got, input int hold, input bit toggle);
    if (lat + 1 >= hold)
      start = (toggle && !got) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // lat counts clock edges after the capture edge until done is first seen;
  // a zero divisor goes straight to FINISH on the capture edge itself.
  task automatic run_op(input logic signed [2*W-1:0] a, input logic signed [W-1:0] b,
                        input int hold, input bit toggle);
    int lat;
    bit got;
    int exp_lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(model(int'(a), int'(b)));
    exp_lat = (b == 0) ? 0 : 2 * W;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    if (done) got = 1'b1;
    drive_start(lat, got, hold, toggle);
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) got = 1'b1;
      drive_start(lat, got, hold, toggle);
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done at %0d", lat, exp_lat);
      start = 1'b0;
    end else begin
      check("latency", 64'(lat), 64'(exp_lat));
    end
    while (start && lat < 80) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      check("done_held", 64'(done), 64'd1);
      drive_start(lat, 1'b1, hold, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    check("done_drop", 64'(done), 64'd0);
  endtask

  initial begin
    logic signed [2*W-1:0] ra;
    logic signed [W-1:0]   rb;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // sign combinations, boundaries, overflow and zero divisor
    run_op(16'sd100, 8'sd7, 1, 1'b0);
    run_op(-16'sd100, 8'sd7, 1, 1'b0);
    run_op(16'sd100, -8'sd7, 1, 1'b0);
    run_op(-16'sd100, -8'sd7, 1, 1'b0);
    run_op(16'sd16384, -8'sd128, 1, 1'b0);
    run_op(16'sd1000, 8'sd7, 1, 1'b0);
    run_op(-16'sd16384, -8'sd128, 1, 1'b0);
    run_op(-16'sd32768, 8'sd1, 1, 1'b0);
    run_op(16'sd55, 8'sd0, 1, 1'b0);
    run_op(-16'sd21, 8'sd7, 1, 1'b0);

    // start held through the whole operation, then start toggled during RUN
    run_op(16'sd100, 8'sd7, 30, 1'b0);
    run_op(-16'sd1234, 8'sd77, 1, 1'b1);
    run_op(16'sd100, 8'sd7, 1, 1'b0);

    // asynchronous reset part-way through RUN
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_done", 64'(done), 64'd0);
    check("abort_outputs", 64'({div_by_zero, overflow, quotient, remainder}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_idle_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_op(16'sd100, 8'sd7, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $signed(16'($urandom)) >>> $urandom_range(0, 15);
      rb = ($urandom_range(0, 15) == 0) ? 8'sd0 : $signed(8'($urandom));
      run_op(ra, rb, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
